// File: rtl/addertree_final_acc.sv
// Final carry-propagate add and signed group accumulator behind the compressor tree.
// Two-stage elastic pipeline: S1 registers the carry-save rows, S2 accumulates and holds the result.
module addertree_final_acc #(
    parameter int IN_W  = 20,
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_row_a,
    input  logic [IN_W-1:0]  in_row_b,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic             s1_valid;
    logic [IN_W-1:0]  s1_row_a;
    logic [IN_W-1:0]  s1_row_b;
    logic             s1_first;
    logic             s1_last;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             in_group;

    logic             stall;
    logic             s2_run;
    logic             new_group;
    logic [IN_W-1:0]  row_sum;
    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W:0]   acc_wide;
    logic             sat_hit;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             ovf_next;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall | ~s1_valid;
    assign s2_run   = s1_valid & ~stall;

    // The row sum wraps at IN_W bits on purpose: the tree's sign-correction constants rely on it.
    always_comb begin
        row_sum   = s1_row_a + s1_row_b;
        sum_ext   = {{(ACC_W-IN_W){row_sum[IN_W-1]}}, row_sum};
        new_group = s1_first | ~in_group;
        acc_wide  = {acc[ACC_W-1], acc} + {sum_ext[ACC_W-1], sum_ext};
        sat_hit   = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
        acc_next  = acc_wide[ACC_W-1:0];
        cnt_next  = cnt;
        ovf_next  = ovf;
        if (new_group) begin
            acc_next = sum_ext;
            cnt_next = CNT_W'(1);
            ovf_next = 1'b0;
        end else begin
            if (sat_hit) begin
                acc_next = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
            end
            if (cnt != CNT_MAX) begin
                cnt_next = cnt + CNT_W'(1);
            end
            ovf_next = ovf | sat_hit;
        end
    end

    // S1 keeps loading while it is empty even under a stall, so nothing accepted is ever dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_row_a  <= '0;
            s1_row_b  <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            in_group  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_cnt   <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                s1_row_a <= in_row_a;
                s1_row_b <= in_row_b;
                s1_first <= in_first;
                s1_last  <= in_last;
            end
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (s2_run) begin
                acc <= acc_next;
                cnt <= cnt_next;
                ovf <= ovf_next;
                if (s1_last) begin
                    out_data  <= acc_next;
                    out_ovf   <= ovf_next;
                    out_cnt   <= cnt_next;
                    out_valid <= 1'b1;
                    in_group  <= 1'b0;
                end else begin
                    in_group  <= 1'b1;
                end
            end
        end
    end

endmodule
